// File: rtl/down_timer_if.sv
// Control/status bundle for down_timer: load/start/pause/auto_reload in, count and status out.
interface down_timer_if #(
    parameter int unsigned WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] in;
    logic             start;
    logic             pause;
    logic             auto_reload;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             expired;
    logic             done;

    modport master (
        output load, in, start, pause, auto_reload,
        input  q, busy, expired, done
    );

    modport slave (
        input  load, in, start, pause, auto_reload,
        output q, busy, expired, done
    );
endinterface

// File: rtl/down_timer.sv
// Loadable down-counter with pause, one-shot or auto-reload expiry and a one-cycle done pulse.
module down_timer #(
    parameter int unsigned WIDTH = 4
) (
    input logic         clk,
    input logic         clr,
    down_timer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        HOLD    = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] q_r, q_nxt;
    logic [WIDTH-1:0] reload_val, reload_nxt;
    logic             done_r, done_nxt;

    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= IDLE;
            q_r        <= '0;
            reload_val <= '0;
            done_r     <= 1'b0;
        end else begin
            state      <= state_nxt;
            q_r        <= q_nxt;
            reload_val <= reload_nxt;
            done_r     <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        q_nxt      = q_r;
        reload_nxt = reload_val;
        done_nxt   = 1'b0;
        if (bus.load) begin
            q_nxt      = bus.in;
            reload_nxt = bus.in;
            state_nxt  = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (q_r != '0) begin
                            state_nxt = RUN;
                        end else begin
                            state_nxt = EXPIRED;
                            done_nxt  = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.pause) begin
                        state_nxt = HOLD;
                    end else if (q_r > ONE) begin
                        q_nxt = q_r - ONE;
                    end else if (q_r == ONE) begin
                        q_nxt    = '0;
                        done_nxt = 1'b1;
                        if (!bus.auto_reload) state_nxt = EXPIRED;
                    end else begin
                        // The zero cycle is what makes the reload period reload_val+1.
                        if (bus.auto_reload) q_nxt = reload_val;
                        else                 state_nxt = EXPIRED;
                    end
                end
                HOLD: begin
                    if (!bus.pause) state_nxt = RUN;
                end
                EXPIRED: begin
                    if (bus.start) begin
                        q_nxt = reload_val;
                        if (reload_val != '0) state_nxt = RUN;
                        else                  done_nxt  = 1'b1;
                    end else begin
                        q_nxt = '0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign bus.q       = q_r;
    assign bus.busy    = (state == RUN) || (state == HOLD);
    assign bus.expired = (state == EXPIRED);
    assign bus.done    = done_r;
endmodule

// File: doc/down_timer.md
DOWN_TIMER -- requirements
Module: down_timer

Interface
REQ-001 Parameter: WIDTH, default 4, counter and load-value width in bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 clr  input  1  synchronous, active-high reset; SHALL take effect only on a rising clk edge.
REQ-004 load  input  1  when high, captures in as the count and reload value.
REQ-005 in  input  WIDTH  load value.
REQ-006 start  input  1  begins a countdown from IDLE, or restarts one from EXPIRED.
REQ-007 pause  input  1  level; while high in RUN/HOLD, the count is frozen.
REQ-008 auto_reload  input  1  level; when high, the count reloads on expiry instead of stopping.
REQ-009 q  output  WIDTH  current count (registered).
REQ-010 busy  output  1  high in RUN or HOLD.
REQ-011 expired  output  1  high in EXPIRED.
REQ-012 done  output  1  registered one-cycle expiry pulse.

Function
REQ-013 Internal registers SHALL be q, reload_val[WIDTH-1:0], and a state register (IDLE, RUN, HOLD, EXPIRED).
REQ-014 Per-edge priority SHALL be: clr, then load, then state-machine behaviour.
REQ-015 load=1 (any state): q<=in, reload_val<=in, state<=IDLE, done<=0; start and pause are ignored that edge.
REQ-016 done SHALL be 0 on every edge not explicitly setting it to 1.
REQ-017 IDLE, start=1, q!=0: state<=RUN; q is unchanged that edge, and decrementing begins on the next edge.
REQ-018 IDLE, start=1, q==0: state<=EXPIRED, done<=1.
REQ-019 RUN, pause=1: state<=HOLD; q is unchanged.
REQ-020 RUN, pause=0, q>1: q<=q-1.
REQ-021 RUN, pause=0, q==1: q<=0, done<=1; state<=RUN if auto_reload=1, else EXPIRED.
REQ-022 RUN, pause=0, q==0: if auto_reload=1, q<=reload_val and state stays RUN; if auto_reload=0, state<=EXPIRED with no done.
REQ-023 HOLD: pause=0 SHALL return to RUN without changing q that edge; pause=1 stays in HOLD; start is ignored.
REQ-024 EXPIRED, start=1: q<=reload_val; state<=RUN if reload_val!=0, else state stays EXPIRED with done<=1.
REQ-025 EXPIRED, start=0: q SHALL hold 0.
REQ-026 The auto-reload period SHALL be reload_val+1 cycles, with one done pulse per period.
REQ-027 q SHALL never wrap below 0.
REQ-028 Arithmetic SHALL be unsigned, modulo WIDTH.
REQ-029 busy and expired SHALL be decoded from the state register only (glitch-free, registered source).

Reset
REQ-030 clr=1 SHALL set q=0, reload_val=0, state=IDLE, done=0, busy=0, expired=0 on the same edge, overriding load and start.
REQ-031 clr asserted mid-countdown SHALL abort with no done pulse.
REQ-032 Outputs SHALL be undefined only before the first clr edge; the bench SHALL apply clr before checking.

Verification
REQ-033 Reset: clr=1 for 2 edges -> q=0, busy=0, expired=0, done=0.
REQ-034 One-shot: load in=5, then start for 1 cycle (auto_reload=0) -> q sequence 5,5,4,3,2,1,0; done=1 only in the cycle q first reads 0; then expired=1, busy=0.
REQ-035 Auto-reload: load 3, auto_reload=1, start -> q sequence 3,3,2,1,0,3,2,1,0,...; done pulses every 4 cycles; busy stays 1.
REQ-036 Pause: one-shot from 7, pause=1 for 3 cycles while q=4 -> q holds 4 for 3 cycles, then resumes at 3; no extra done.
REQ-037 Mid-run abort: at q=2, load with in=9 -> q=9, IDLE, no done. Repeat with clr instead -> q=0, IDLE, no done.
REQ-038 Zero start: after clr, start -> done=1 for exactly one cycle, expired=1, q stays 0. Start again from EXPIRED with reload_val=0 -> one more done pulse.
